dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Two-port arbiter and sequencer in front of the single-port 256-word data memory.
//  Port 0 = core load/store unit, port 1 = DMA/debug master; at most one access per cycle.
//  Round-robin grant, valid/ready request handshake, registered 1-cycle read response.
//  Drives the memory's write-enable/address/write-data and samples its combinational read data.
// PARAMETERS
//  ADDR_W     32   request address width (word address)
//  DATA_W     32   data width
//  DEPTH      256  memory words; addresses >= DEPTH are out of range
//  MAX_BURST  4    max consecutive beats one locked port may hold the grant (DMEM_ARB_LOCK_EN only)
// PORTS
//  i_Clk          in   1       clock, all state on rising edge
//  i_Reset        in   1       reset, synchronous, active-low
//  i_ReqN_Valid   in   1       N=0,1: request present
//  i_ReqN_Write   in   1       1 = write, 0 = read
//  i_ReqN_Addr    in   ADDR_W  word address
//  i_ReqN_wData   in   DATA_W  write data
//  i_ReqN_Lock    in   1       hold grant for following beats (DMEM_ARB_LOCK_EN only)
//  o_ReqN_Ready   out  1       request accepted this cycle (valid & ready = accept)
//  o_RspN_Valid   out  1       read data valid (one cycle pulse)
//  o_RspN_rData   out  DATA_W  read data
//  o_RspN_Err     out  1       with o_RspN_Valid: accepted access was out of range
//  o_Mem_wEnable  out  1       memory write enable
//  o_Mem_Addr     out  ADDR_W  memory address
//  o_Mem_wData    out  DATA_W  memory write data
//  i_Mem_rData    in   DATA_W  memory combinational read data
// BEHAVIOUR
//  Reset (i_Reset=0 at edge): o_RspN_Valid/Err=0, o_RspN_rData=0, rr pointer=1 (port 0 wins first),
//   state=ARB, beat counter=0. While i_Reset=0: o_ReqN_Ready=0, o_Mem_wEnable=0 (no write escapes).
//  Grant (combinational): only one valid -> that port; both valid -> port != rr pointer.
//   o_ReqN_Ready = grant to N; never both high. Ready may depend on Valid; Valid must not wait on Ready.
//  Accept cycle: o_Mem_Addr/wData = granted port's; o_Mem_wEnable = Write & in-range. No grant:
//   o_Mem_Addr=0, o_Mem_wData=0, o_Mem_wEnable=0. rr pointer <= accepted port at edge.
//  Read response: accepted read -> next cycle o_RspN_Valid=1, rData = i_Mem_rData sampled at accept
//   edge; latency exactly 1; back-to-back reads give back-to-back responses. Writes give no response.
//  Out of range (Addr >= DEPTH, compare full ADDR_W): still accepted; write suppressed; next cycle
//   o_RspN_Valid=1, o_RspN_Err=1, o_RspN_rData=0 for both reads and writes.
//  Same-cycle read+write impossible (single grant). Write then read same address next cycle returns new data.
//  Reset mid-operation: pending response dropped, no response after reset releases.
// CONFIGURATION
//  DMEM_ARB_LOCK_EN defined: FSM ARB -> LOCKN when port N accepted with i_ReqN_Lock=1 (counter=1).
//   LOCKN: only port N granted, other port Ready=0; each accept counter++; exit to ARB when
//   accepted beat has Lock=0, counter reaches MAX_BURST, or port N Valid=0 a cycle; on exit rr pointer=N.
//  Not defined: i_ReqN_Lock ports absent, FSM stays ARB, pure round-robin.
// STRUCTURE
//  Package dmem_arb_pkg: arb_state_e {ARB, LOCK0, LOCK1}, DMEM_DEPTH=256, PORT_CORE=0, PORT_DMA=1.
//  Sub-module dmem_rr_picker: 2-way grant from valids + rr pointer (+ lock owner mask); combinational.
// TESTING
//  Reset: hold i_Reset=0 with both valid writes -> Ready=0, o_Mem_wEnable=0, all Rsp outputs 0.
//  Contention: both read addr 5/6 every cycle -> grants alternate 0,1,0,1; port 0 first; each Rsp 1 cycle later.
//  Write/read: port1 writes 0xDEADBEEF@10, port0 reads 10 next cycle -> o_Rsp0_rData=0xDEADBEEF.
//  Range: port0 write addr 256 -> wEnable=0, Rsp0 Valid=1 Err=1 rData=0; addr 255 -> normal write.
//  Lock (LOCK_EN): port1 Lock=1 for 6 beats, port0 valid -> port1 gets 4 beats, then port0 granted.
//  Reset mid-read: accept read, drop i_Reset next cycle -> o_Rsp0_Valid never asserts.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
//   arb_state_e    : arbiter FSM states (ARB = round-robin, LOCKn = port n owns the grant)
//   DMEM_DEPTH     : number of memory words; word addresses >= this are out of range
//   DMEM_MAX_BURST : default longest locked burst
//   PORT_CORE/PORT_DMA : port indices (0 = core load/store, 1 = DMA/debug)
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_e;

  localparam int DMEM_DEPTH     = 256;
  localparam int DMEM_MAX_BURST = 4;
  localparam int PORT_CORE      = 0;
  localparam int PORT_DMA       = 1;

endpackage

// File: rtl/dmem_rr_picker.sv
// Two-way combinational grant picker.
//   valid  in  [1:0]  request present per port (already qualified by reset)
//   rr_ptr in  1      port that was granted last; it loses a tie
//   mask   in  [1:0]  ports allowed to win this cycle (lock owner only while locked)
//   grant  out [1:0]  one-hot or zero; never both bits set
module dmem_rr_picker
  import dmem_arb_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       rr_ptr,
  input  logic [1:0] mask,
  output logic [1:0] grant
);

  logic [1:0] cand;

  always_comb begin
    cand  = valid & mask;
    grant = cand;
    // Tie: the port that was not served last wins.
    if (cand == 2'b11) begin
      grant            = 2'b00;
      grant[PORT_CORE] = rr_ptr;
      grant[PORT_DMA]  = ~rr_ptr;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer in front of a single-port data memory.
// Port 0 is the core load/store unit, port 1 the DMA/debug master. One access per cycle,
// round-robin between the ports, reads answered exactly one cycle after acceptance.
//
// Handshake: a request is accepted in any cycle where o_ReqN_Ready and i_ReqN_Valid are
// both high. Ready is a combinational function of Valid (and arbiter state); a master must
// raise Valid without waiting for Ready.
//
// Ports:
//   i_Clk, i_Reset          clock; synchronous active-low reset
//   i_ReqN_Valid/Write/Addr/wData   request N (N = 0, 1)
//   i_ReqN_Lock             keep the grant for following beats (DMEM_ARB_LOCK_EN builds only)
//   o_ReqN_Ready            request N accepted this cycle
//   o_RspN_Valid/rData/Err  one-cycle response for reads and for out-of-range accesses
//   o_Mem_wEnable/Addr/wData  memory drive; i_Mem_rData memory combinational read data
//   o_Dbg_State             current arbiter FSM state (arb_state_e encoding)
//
// Build option: define DMEM_ARB_LOCK_EN to add the lock ports and locked-burst FSM states.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int DEPTH     = DMEM_DEPTH,
  parameter int MAX_BURST = DMEM_MAX_BURST
) (
  input  logic              i_Clk,
  input  logic              i_Reset,
  input  logic              i_Req0_Valid,
  input  logic              i_Req0_Write,
  input  logic [ADDR_W-1:0] i_Req0_Addr,
  input  logic [DATA_W-1:0] i_Req0_wData,
  input  logic              i_Req1_Valid,
  input  logic              i_Req1_Write,
  input  logic [ADDR_W-1:0] i_Req1_Addr,
  input  logic [DATA_W-1:0] i_Req1_wData,
`ifdef DMEM_ARB_LOCK_EN
  input  logic              i_Req0_Lock,
  input  logic              i_Req1_Lock,
`endif
  output logic              o_Req0_Ready,
  output logic              o_Req1_Ready,
  output logic              o_Rsp0_Valid,
  output logic [DATA_W-1:0] o_Rsp0_rData,
  output logic              o_Rsp0_Err,
  output logic              o_Rsp1_Valid,
  output logic [DATA_W-1:0] o_Rsp1_rData,
  output logic              o_Rsp1_Err,
  output logic              o_Mem_wEnable,
  output logic [ADDR_W-1:0] o_Mem_Addr,
  output logic [DATA_W-1:0] o_Mem_wData,
  input  logic [DATA_W-1:0] i_Mem_rData,
  output logic [1:0]        o_Dbg_State
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);

  logic [1:0]        valid;
  logic [1:0]        write;
  logic [1:0]        lock;
  logic [1:0]        oor;
  logic [1:0]        mask;
  logic [1:0]        grant;
  logic [ADDR_W-1:0] addr  [2];
  logic [DATA_W-1:0] wdata [2];

  logic              any_acc;
  logic              acc_port;
  logic              owner;

  arb_state_e        state_q, state_d;
  logic              rr_q, rr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [1:0]        rsp_valid_q;
  logic [1:0]        rsp_err_q;
  logic [DATA_W-1:0] rsp_data_q [2];

  // Holding reset low masks every request, so nothing is granted and no write escapes.
  assign valid    = {i_Req1_Valid, i_Req0_Valid} & {2{i_Reset}};
  assign write    = {i_Req1_Write, i_Req0_Write};
  assign addr[0]  = i_Req0_Addr;
  assign addr[1]  = i_Req1_Addr;
  assign wdata[0] = i_Req0_wData;
  assign wdata[1] = i_Req1_wData;

`ifdef DMEM_ARB_LOCK_EN
  assign lock = {i_Req1_Lock, i_Req0_Lock};
`else
  assign lock = 2'b00;
`endif

  // Range check on the full address width, so high garbage bits never alias into the array.
  assign oor[0] = {1'b0, addr[0]} >= (ADDR_W + 1)'(DEPTH);
  assign oor[1] = {1'b0, addr[1]} >= (ADDR_W + 1)'(DEPTH);

  always_comb begin
    case (state_q)
      LOCK0:   mask = 2'b01;
      LOCK1:   mask = 2'b10;
      default: mask = 2'b11;
    endcase
  end

  dmem_rr_picker u_picker (
    .valid  (valid),
    .rr_ptr (rr_q),
    .mask   (mask),
    .grant  (grant)
  );

  assign any_acc  = |grant;
  assign acc_port = grant[1];
  assign owner    = (state_q == LOCK1);

  assign o_Req0_Ready  = grant[0];
  assign o_Req1_Ready  = grant[1];
  assign o_Mem_wEnable = any_acc & write[acc_port] & ~oor[acc_port];
  assign o_Mem_Addr    = any_acc ? addr[acc_port]  : '0;
  assign o_Mem_wData   = any_acc ? wdata[acc_port] : '0;

  // Arbiter FSM: state register.
  always_ff @(posedge i_Clk) begin
    if (!i_Reset) begin
      state_q <= ARB;
      rr_q    <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Arbiter FSM: next state. cnt counts beats accepted within the current lock.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    case (state_q)
      ARB: begin
        if (any_acc) begin
          rr_d = acc_port;
          if (lock[acc_port] && (MAX_BURST > 1)) begin
            state_d = acc_port ? LOCK1 : LOCK0;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      LOCK0, LOCK1: begin
        if (!valid[owner]) begin
          // Owner went idle: release, and let the other port win the next tie.
          state_d = ARB;
          rr_d    = owner;
          cnt_d   = '0;
        end else if (any_acc) begin
          rr_d  = owner;
          cnt_d = cnt_q + 1'b1;
          if (!lock[owner] || (cnt_d == CNT_W'(MAX_BURST))) begin
            state_d = ARB;
            cnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = ARB;
        cnt_d   = '0;
      end
    endcase
  end

  assign o_Dbg_State = state_q;

  // Response registers: reads and out-of-range accesses answer one cycle after acceptance.
  always_ff @(posedge i_Clk) begin
    if (!i_Reset) begin
      rsp_valid_q   <= '0;
      rsp_err_q     <= '0;
      rsp_data_q[0] <= '0;
      rsp_data_q[1] <= '0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        rsp_valid_q[p] <= grant[p] & (~write[p] | oor[p]);
        rsp_err_q[p]   <= grant[p] & oor[p];
        rsp_data_q[p]  <= (grant[p] & ~write[p] & ~oor[p]) ? i_Mem_rData : '0;
      end
    end
  end

  // Reset asserted the cycle after an accept must still kill the pending response,
  // so the registered outputs are qualified by reset as well.
  assign o_Rsp0_Valid = rsp_valid_q[0] & i_Reset;
  assign o_Rsp0_Err   = rsp_err_q[0] & i_Reset;
  assign o_Rsp0_rData = rsp_data_q[0] & {DATA_W{i_Reset}};
  assign o_Rsp1_Valid = rsp_valid_q[1] & i_Reset;
  assign o_Rsp1_Err   = rsp_err_q[1] & i_Reset;
  assign o_Rsp1_rData = rsp_data_q[1] & {DATA_W{i_Reset}};

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: fixed vector table, hand sequences for reset and lock corners,
// then random traffic against a transaction-level model (array memory + response queues).
module tb_dmem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int DEPTH = 256;
  localparam int MAXB = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [1:0]    v, w, lk;
  logic [AW-1:0] a [2];
  logic [DW-1:0] d [2];
  logic          r0, r1;
  logic          rsp0_v, rsp0_e, rsp1_v, rsp1_e;
  logic [DW-1:0] rsp0_d, rsp1_d;
  logic          mem_wen;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [1:0]    dbg_state;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .MAX_BURST(MAXB)) dut (
    .i_Clk         (clk),
    .i_Reset       (rst),
    .i_Req0_Valid  (v[0]),
    .i_Req0_Write  (w[0]),
    .i_Req0_Addr   (a[0]),
    .i_Req0_wData  (d[0]),
    .i_Req1_Valid  (v[1]),
    .i_Req1_Write  (w[1]),
    .i_Req1_Addr   (a[1]),
    .i_Req1_wData  (d[1]),
`ifdef DMEM_ARB_LOCK_EN
    .i_Req0_Lock   (lk[0]),
    .i_Req1_Lock   (lk[1]),
`endif
    .o_Req0_Ready  (r0),
    .o_Req1_Ready  (r1),
    .o_Rsp0_Valid  (rsp0_v),
    .o_Rsp0_rData  (rsp0_d),
    .o_Rsp0_Err    (rsp0_e),
    .o_Rsp1_Valid  (rsp1_v),
    .o_Rsp1_rData  (rsp1_d),
    .o_Rsp1_Err    (rsp1_e),
    .o_Mem_wEnable (mem_wen),
    .o_Mem_Addr    (mem_addr),
    .o_Mem_wData   (mem_wdata),
    .i_Mem_rData   (mem_rdata),
    .o_Dbg_State   (dbg_state)
  );

  function automatic logic [DW-1:0] seed(int i);
    return 32'hA500_0000 ^ (32'(i) * 32'h0001_0203);
  endfunction

  // Memory behind the arbiter: combinational read, write on clock edge.
  logic [DW-1:0] env_mem [DEPTH];
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) env_mem[i] <= seed(i);
    end else if (mem_wen) begin
      env_mem[mem_addr[7:0]] <= mem_wdata;
    end
  end
  assign mem_rdata = env_mem[mem_addr[7:0]];

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk1(string name, logic act, logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk32(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW:0]   exp_q0 [$];   // {err, data}
  logic [DW:0]   exp_q1 [$];
  int            m_last  = 1;  // port served last
  int            m_owner = -1; // lock owner, -1 when none
  int            m_beats = 0;

  logic hand_en = 1'b0;
  logic hand_r0, hand_r1;

  function automatic int model_pick();
    if (!rst) return -1;
    if (m_owner >= 0) return v[m_owner] ? m_owner : -1;
    if (v[0] && v[1]) return (m_last == 0) ? 1 : 0;
    if (v[0]) return 0;
    if (v[1]) return 1;
    return -1;
  endfunction

  task automatic model_update(int p);
    logic oor;
    if (!rst) begin
      m_last = 1; m_owner = -1; m_beats = 0;
      exp_q0.delete(); exp_q1.delete();
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = seed(i);
      return;
    end
    if (p < 0) begin
      if (m_owner >= 0 && !v[m_owner]) begin
        m_last = m_owner;
        m_owner = -1;
      end
      return;
    end
    oor = (a[p] >= AW'(DEPTH));
    if (w[p] && !oor) ref_mem[a[p][7:0]] = d[p];
    if (!w[p] || oor) begin
      if (p == 0) exp_q0.push_back(oor ? {1'b1, 32'h0} : {1'b0, ref_mem[a[p][7:0]]});
      else        exp_q1.push_back(oor ? {1'b1, 32'h0} : {1'b0, ref_mem[a[p][7:0]]});
    end
    m_last = p;
`ifdef DMEM_ARB_LOCK_EN
    if (m_owner < 0) begin
      if (lk[p]) begin m_owner = p; m_beats = 1; end
    end else begin
      m_beats++;
      if (!lk[p] || m_beats >= MAXB) m_owner = -1;
    end
`endif
  endtask

  // One clock: compare at the falling edge, advance the model at the rising edge.
  task automatic tick();
    int p;
    logic [DW:0] e;
    logic ev;
    @(negedge clk);
    p = model_pick();
    chk1("ready0", r0, p == 0);
    chk1("ready1", r1, p == 1);
    if (hand_en) begin
      chk1("hand_ready0", r0, hand_r0);
      chk1("hand_ready1", r1, hand_r1);
    end
    chk1("mem_wen", mem_wen, (p >= 0) ? (w[p] && (a[p] < AW'(DEPTH))) : 1'b0);
    chk32("mem_addr", mem_addr, (p >= 0) ? a[p] : 32'h0);
    chk32("mem_wdata", mem_wdata, (p >= 0) ? d[p] : 32'h0);
    ev = 1'b0; e = '0;
    if (exp_q0.size() > 0) begin e = exp_q0.pop_front(); ev = rst; end
    chk1("rsp0_valid", rsp0_v, ev);
    if (ev) begin
      chk1("rsp0_err", rsp0_e, e[DW]);
      chk32("rsp0_rdata", rsp0_d, e[DW-1:0]);
    end
    ev = 1'b0; e = '0;
    if (exp_q1.size() > 0) begin e = exp_q1.pop_front(); ev = rst; end
    chk1("rsp1_valid", rsp1_v, ev);
    if (ev) begin
      chk1("rsp1_err", rsp1_e, e[DW]);
      chk32("rsp1_rdata", rsp1_d, e[DW-1:0]);
    end
    if (!rst) begin
      chk1("rst_rsp0_err", rsp0_e, 1'b0);
      chk32("rst_rsp0_rdata", rsp0_d, 32'h0);
      chk1("rst_rsp1_err", rsp1_e, 1'b0);
      chk32("rst_rsp1_rdata", rsp1_d, 32'h0);
    end
    @(posedge clk);
    model_update(p);
    #1;
  endtask

  // ---------------- driver ----------------
  task automatic drive(logic v0, logic w0, logic [31:0] a0, logic [31:0] d0,
                       logic v1, logic w1, logic [31:0] a1, logic [31:0] d1);
    v = {v1, v0}; w = {w1, w0};
    a[0] = a0; d[0] = d0; a[1] = a1; d[1] = d1;
  endtask

  typedef struct {
    logic v0, w0; logic [31:0] a0, d0;
    logic v1, w1; logic [31:0] a1, d1;
    logic r0, r1;
  } vec_t;

  vec_t tbl [12];

  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = seed(i);
    lk = 2'b00;

    // Reset held with both ports requesting writes.
    rst = 1'b0;
    drive(1, 1, 32'd7, 32'h1111_1111, 1, 1, 32'd8, 32'h2222_2222);
    repeat (3) tick();
    rst = 1'b1;

    tbl[0]  = '{1, 0, 32'd5,   32'h0,          1, 0, 32'd6,   32'h0,          1, 0};
    tbl[1]  = '{1, 0, 32'd5,   32'h0,          1, 0, 32'd6,   32'h0,          0, 1};
    tbl[2]  = '{1, 0, 32'd5,   32'h0,          1, 0, 32'd6,   32'h0,          1, 0};
    tbl[3]  = '{1, 0, 32'd5,   32'h0,          1, 0, 32'd6,   32'h0,          0, 1};
    tbl[4]  = '{0, 0, 32'd0,   32'h0,          1, 1, 32'd10,  32'hDEAD_BEEF,  0, 1};
    tbl[5]  = '{1, 0, 32'd10,  32'h0,          0, 0, 32'd0,   32'h0,          1, 0};
    tbl[6]  = '{1, 1, 32'd256, 32'hBAD0_BAD0,  0, 0, 32'd0,   32'h0,          1, 0};
    tbl[7]  = '{1, 1, 32'd255, 32'h1234_5678,  0, 0, 32'd0,   32'h0,          1, 0};
    tbl[8]  = '{1, 0, 32'd255, 32'h0,          0, 0, 32'd0,   32'h0,          1, 0};
    tbl[9]  = '{0, 0, 32'd0,   32'h0,          0, 0, 32'd0,   32'h0,          0, 0};
    tbl[10] = '{0, 0, 32'd0,   32'h0,          1, 0, 32'h8000_0000, 32'h0,    0, 1};
    tbl[11] = '{1, 0, 32'd1,   32'h0,          1, 0, 32'd2,   32'h0,          1, 0};

    hand_en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].v0, tbl[i].w0, tbl[i].a0, tbl[i].d0,
            tbl[i].v1, tbl[i].w1, tbl[i].a1, tbl[i].d1);
      hand_r0 = tbl[i].r0;
      hand_r1 = tbl[i].r1;
      tick();
    end
    hand_en = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    // The write at 10 followed by the read must have returned the written word.
    chk32("ref_addr10", ref_mem[10], 32'hDEAD_BEEF);

    // Reset asserted the cycle after an accepted read: that response must never appear.
    drive(1, 0, 32'd3, 32'h0, 0, 0, 0, 0);
    tick();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) tick();
    rst = 1'b1;
    repeat (3) tick();

`ifdef DMEM_ARB_LOCK_EN
    // Port 0 served last, so port 1 wins the tie, locks, and keeps 4 beats.
    drive(1, 0, 32'd30, 32'h0, 0, 0, 0, 0);
    tick();
    drive(1, 0, 32'd30, 32'h0, 1, 0, 32'd20, 32'h0);
    lk = 2'b10;
    hand_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      hand_r1 = (i < 4) || (i == 5);
      hand_r0 = (i == 4);
      tick();
    end
    hand_en = 1'b0;
    lk = 2'b00;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) tick();
`endif

    // Random traffic, including occasional reset and boundary addresses.
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 99) != 0);
      for (int p = 0; p < 2; p++) begin
        v[p] = ($urandom_range(0, 9) < 7);
        w[p] = $urandom_range(0, 1);
        a[p] = ($urandom_range(0, 3) == 0) ? 32'(250 + $urandom_range(0, 10))
                                           : 32'($urandom_range(0, 15));
        d[p] = $urandom;
`ifdef DMEM_ARB_LOCK_EN
        lk[p] = ($urandom_range(0, 2) != 0);
`endif
      end
      tick();
    end
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
